// File: rtl/serial_add_if.sv
// Operand/result bundle for the bit-serial adder; the ovf signal exists only
// when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOUT;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, carryIN,
                  input  busy, done, sum, carryOUT, ovf);
  modport slave  (input  start, a, b, carryIN,
                  output busy, done, sum, carryOUT, ovf);
`else
  modport master (output start, a, b, carryIN,
                  input  busy, done, sum, carryOUT);
  modport slave  (input  start, a, b, carryIN,
                  output busy, done, sum, carryOUT);
`endif
endinterface

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder driving one combinational full adder, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow flag.
module f_add (
  input  logic a,
  input  logic b,
  input  logic carryIN,
  output logic sum,
  output logic carryOUT
);
  assign sum      = a ^ b ^ carryIN;
  assign carryOUT = (a & b) | (a & carryIN) | (b & carryIN);
endmodule

module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus,
  output logic [1:0]   dbgState
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] shA;
  logic [WIDTH-1:0] shB;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] sumQ;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             carryQ;
  logic             faSum;
  logic             faCarry;
  logic             lastBit;

  f_add u_fadd (
    .a        (shA[0]),
    .b        (shB[0]),
    .carryIN  (cy),
    .sum      (faSum),
    .carryOUT (faCarry)
  );

  assign accNext = {faSum, acc[WIDTH-1:1]};
  assign lastBit = (cnt == CW'(WIDTH - 1));

  // Handshake: start is sampled only while busy=0; once accepted, busy stays
  // high through RUN and DONE, and done pulses one cycle with sum/carryOUT valid.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (lastBit)   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shA    <= '0;
      shB    <= '0;
      acc    <= '0;
      sumQ   <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      carryQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shA <= bus.a;
            shB <= bus.b;
            cy  <= bus.carryIN;
            cnt <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          acc <= accNext;
          cy  <= faCarry;
          shA <= shA >> 1;
          shB <= shB >> 1;
          if (lastBit) begin
            sumQ   <= accNext;
            carryQ <= faCarry;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovfQ;

  // On the last bit cy is the carry into the MSB and faCarry the carry out.
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovfQ <= 1'b0;
    else if (state == RUN && lastBit)  ovfQ <= cy ^ faCarry;
  end

  assign bus.ovf = ovfQ;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sumQ;
  assign bus.carryOUT = carryQ;
  assign dbgState     = state;
endmodule

// File: tb/tb_serial_add.sv
// Randomized scoreboard bench for serial_add: reference adds computed with
// plain integer arithmetic, results checked by an independent monitor.
module tb_serial_add;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbgState;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int actStart = 0;
  int actEnd   = -1;
  bit checkOn  = 1'b0;

  logic [W:0]   exp_q[$];
  int           lat_q[$];
  bit           ovf_q[$];
  logic [W-1:0] prevSum;
  logic         prevCo;
  logic         prevDone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W:0] model_sum(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    longint s;
    s = longint'(av) + longint'(bv) + longint'(ci);
    return (W+1)'(s);
  endfunction

  function automatic bit model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    longint sa, sb, sr;
    sa = (longint'(av) >= (64'sd1 <<< (W-1))) ? longint'(av) - (64'sd1 <<< W) : longint'(av);
    sb = (longint'(bv) >= (64'sd1 <<< (W-1))) ? longint'(bv) - (64'sd1 <<< W) : longint'(bv);
    sr = sa + sb + longint'(ci);
    return (sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)));
  endfunction

  // Driver: wait for idle, present one start pulse; optionally expect a result.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input bit expect_it);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      check("idle_wait_timeout", 64'(bus.busy), 64'd0);
      return;
    end
    bus.start   = 1'b1;
    bus.a       = av;
    bus.b       = bv;
    bus.carryIN = ci;
    actStart = cyc + 1;
    actEnd   = cyc + 1 + W;
    if (expect_it) begin
      exp_q.push_back(model_sum(av, bv, ci));
      lat_q.push_back(cyc + 1 + W);
      ovf_q.push_back(model_ovf(av, bv, ci));
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.a       = W'($urandom);
    bus.b       = W'($urandom);
    bus.carryIN = 1'($urandom);
  endtask

  // One-cycle start while the DUT is busy; must be ignored entirely.
  task automatic poke_busy(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.a       = av;
    bus.b       = bv;
    bus.carryIN = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sum"},   64'(bus.sum),      64'd0);
    check({tag, "_carry"}, 64'(bus.carryOUT), 64'd0);
    check({tag, "_busy"},  64'(bus.busy),     64'd0);
    check({tag, "_done"},  64'(bus.done),     64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"},   64'(bus.ovf),      64'd0);
`endif
  endtask

  // Monitor: busy window, result/latency on done, result hold between completions.
  always @(posedge clk) begin
    logic [W:0] e;
    #1;
    if (checkOn) begin
      check("busy", 64'(bus.busy), 64'((cyc >= actStart) && (cyc <= actEnd)));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum",     64'(bus.sum),      64'(e[W-1:0]));
          check("carry",   64'(bus.carryOUT), 64'(e[W]));
          check("latency", 64'(cyc),          64'(lat_q.pop_front()));
`ifdef SERIAL_ADD_OVF_EN
          check("ovf",     64'(bus.ovf),      64'(ovf_q.pop_front()));
`else
          void'(ovf_q.pop_front());
`endif
        end
        check("done_width", 64'(prevDone), 64'd0);
      end else begin
        check("held_result", 64'({bus.carryOUT, bus.sum}), 64'({prevCo, prevSum}));
      end
    end
    prevSum  = bus.sum;
    prevCo   = bus.carryOUT;
    prevDone = bus.done;
  end

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.carryIN = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("reset");
    checkOn = 1'b1;

    do_add(8'h5A, 8'h3C, 1'b0, 1'b1);
    do_add(8'hFF, 8'h00, 1'b1, 1'b1);
    do_add(8'hFF, 8'hFF, 1'b1, 1'b1);
    do_add(8'h7F, 8'h01, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 1'b1);
    do_add(8'hFF, 8'h01, 1'b0, 1'b1);

    // Start ignored while busy, then reasserted in idle.
    do_add(8'h01, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    bus.carryIN = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    do_add(8'hF0, 8'h0F, 1'b0, 1'b1);

    // Reset in the middle of a run abandons it.
    do_add(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOn = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    actEnd = -1;
    check_cleared("midreset");
    checkOn = 1'b1;
    do_add(8'h12, 8'h34, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 9) < 3) poke_busy(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
